// File: rtl/ksa_sum_stage.sv
// Kogge-Stone sum stage: forms sum/cout/flags from final group generates and bit propagates.
// Latency: 1 cycle (result visible after the accepting edge); 1 result/cycle sustained.
// Backpressure: 2-entry skid buffer, in_ready is a flop so out_ready never reaches it combinationally.
//
// Ports:
//   clk, rst_n            rising-edge clock, synchronous active-low reset
//   g_grp[31:0]           group generate G[i:0] (carry-in already folded into bit 0)
//   p_bit[31:0]           bitwise propagate a^b
//   cin                   carry into bit 0
//   in_valid / in_ready   input handshake
//   sum, cout, ovf, zero  registered result word
//   out_valid / out_ready output handshake
//
// Build option: define KSA_SUM_FLAGS_EN to compute and store ovf/zero; otherwise they read 0.

module ksa_sum_stage #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] g_grp,
   input  logic [WIDTH-1:0] p_bit,
   input  logic             cin,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf,
   output logic             zero,
   output logic             out_valid,
   input  logic             out_ready
);

`ifdef KSA_SUM_FLAGS_EN
   typedef struct packed {
      logic [WIDTH-1:0] sum;
      logic             cout;
      logic             ovf;
      logic             zero;
   } res_t;
`else
   typedef struct packed {
      logic [WIDTH-1:0] sum;
      logic             cout;
   } res_t;
`endif

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } state_t;

   state_t           state_q, state_d;
   res_t             main_q, skid_q, res_in;
   logic             in_ready_q;
   logic             in_xfer, out_xfer;
   logic             load_main, load_skid, shift_skid;
   logic [WIDTH-1:0] carry;

   // Carry into bit i is the group generate of everything below it; bit 0 takes cin.
   assign carry = {g_grp[WIDTH-2:0], cin};

   always_comb begin
      res_in      = '0;
      res_in.sum  = p_bit ^ carry;
      res_in.cout = g_grp[WIDTH-1];
`ifdef KSA_SUM_FLAGS_EN
      // Signed overflow: carry into MSB differs from carry out of MSB.
      res_in.ovf  = g_grp[WIDTH-2] ^ g_grp[WIDTH-1];
      res_in.zero = ~|(p_bit ^ carry);
`endif
   end

   assign in_xfer  = in_valid & in_ready_q;
   assign out_xfer = out_valid & out_ready;

   // Next-state and datapath steering.
   always_comb begin
      state_d    = state_q;
      load_main  = 1'b0;
      load_skid  = 1'b0;
      shift_skid = 1'b0;
      case (state_q)
         EMPTY: begin
            if (in_xfer) begin
               load_main = 1'b1;
               state_d   = ONE;
            end
         end
         ONE: begin
            if (in_xfer && out_xfer) begin
               load_main = 1'b1;
            end else if (in_xfer) begin
               load_skid = 1'b1;
               state_d   = FULL;
            end else if (out_xfer) begin
               state_d   = EMPTY;
            end
         end
         FULL: begin
            // in_ready is low here, so only the drain side can move.
            if (out_xfer) begin
               shift_skid = 1'b1;
               state_d    = ONE;
            end
         end
         default: state_d = EMPTY;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= EMPTY;
         main_q     <= '0;
         skid_q     <= '0;
         in_ready_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         // Ready is precomputed from next state so it is a pure flop output.
         in_ready_q <= (state_d != FULL);
         if (load_main) begin
            main_q <= res_in;
         end else if (shift_skid) begin
            main_q <= skid_q;
         end
         if (load_skid) begin
            skid_q <= res_in;
         end
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = (state_q != EMPTY);
   assign sum       = main_q.sum;
   assign cout      = main_q.cout;
`ifdef KSA_SUM_FLAGS_EN
   assign ovf       = main_q.ovf;
   assign zero      = main_q.zero;
`else
   assign ovf       = 1'b0;
   assign zero      = 1'b0;
`endif

endmodule

// File: doc/ksa_sum_stage.md
# ksa_sum_stage

Registered sum stage of the 32-bit Kogge-Stone adder. It sits directly downstream of the final prefix stage (span-16 combine) and takes two inputs: the full-width group generates `G[i:0]` from that stage, and the original bitwise propagates. From these it forms the sum, carry-out and status flags. Results are presented through a 2-entry skid buffer with a valid/ready handshake, so the adder can be pipelined against a stalling consumer without a combinational ready path.

## Interface
Parameters:
- `WIDTH`, 32: operand width. Only 32 is supported; it matches the prefix tree.

Ports:
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  synchronous active-low reset.
- `g_grp`  in  32  group generate `G[i:0]` from the final prefix stage. Carry-in is already folded into bit 0 upstream.
- `p_bit`  in  32  original bitwise propagate `a[i]^b[i]`.
- `cin`  in  1  adder carry-in, the carry into bit 0.
- `in_valid`  in  1  inputs are valid this cycle.
- `in_ready`  out  1  stage can accept; driven from registered state.
- `sum`  out  32  registered sum.
- `cout`  out  1  carry out of bit 31.
- `ovf`  out  1  signed overflow (flag option).
- `zero`  out  1  `sum == 0` (flag option).
- `out_valid`  out  1  result presented.
- `out_ready`  in  1  consumer accepts.

## Operation
Arithmetic, computed combinationally on the input side:
- `c[0]` = `cin`; `c[i]` = `g_grp[i-1]` for i = 1..31.
- `sum[i]` = `p_bit[i] ^ c[i]`.
- `cout` = `g_grp[31]`.
- `ovf` = `g_grp[30] ^ g_grp[31]`, i.e. `c[31] ^ c[32]`.
- `zero` = `~|sum`.

Each result word is {sum, cout, ovf, zero} and is stored as a unit. There are two registers: `main` (drives the outputs) and `skid`.

Transfers:
- Input transfer: `in_valid & in_ready`.
- Output transfer: `out_valid & out_ready`.

State machine:
- EMPTY:
  - Input transfer: load `main`, go to ONE.
- ONE:
  - Input transfer and output transfer: reload `main`, stay in ONE.
  - Input transfer only: load `skid`, go to FULL.
  - Output transfer only: go to EMPTY.
  - Neither: hold.
- FULL:
  - Output transfer: `main` <= `skid`, go to ONE.
  - No input transfer is possible because `in_ready` = 0.

Outputs per state:
- `in_ready` = 1 in EMPTY/ONE and 0 in FULL, taken from the state register.
- `out_valid` = 1 in ONE/FULL.

Ordering and stability:
- Results leave in strict acceptance order. Nothing is dropped or duplicated.
- While `out_valid` = 1 and `out_ready` = 0, `sum`/`cout`/`ovf`/`zero` hold stable.

Reset (`rst_n` low at a clock edge):
- State goes to EMPTY; `main` and `skid` are cleared to 0.
- `in_ready` = 0, `out_valid` = 0, `sum` = 0, `cout` = 0, `ovf` = 0, `zero` = 0.
- No transfer occurs in any cycle where `rst_n` is low.
- Reset mid-operation discards any buffered results.

## Timing
- `in_ready` rises to 1 on the first edge after `rst_n` returns high.
- Latency: input accepted at edge N → `out_valid` = 1 with that result after edge N, consumable at edge N+1.
- Throughput: 1 result/cycle with `out_ready` held high.
- Stall: after 2 results accumulate, `in_ready` falls the edge following the second acceptance. It returns 1 the edge after the next output transfer.
- No combinational path from `out_ready` to `in_ready`. All outputs are registered.
- Simultaneous input and output transfer in ONE: the new result is visible after the same edge.
- `in_valid` may drop without a transfer. Inputs are sampled only on a transfer.

## Configuration
- `KSA_SUM_FLAGS_EN` defined:
  - `ovf` and `zero` are computed as above and stored per entry in both `main` and `skid`.
- `KSA_SUM_FLAGS_EN` undefined:
  - `ovf` and `zero` are tied to 0.
  - No flag storage is built.
  - `sum`, `cout` and the handshake behave identically to the defined build.

## Test plan
The bench derives `g_grp`/`p_bit` from operands `a`, `b` with a reference prefix model, with `cin` folded in.
- Reset held 3 cycles with `in_valid` = 1 → all outputs 0 during reset, no transfer. `in_ready` = 1 one edge after release.
- `a`=0xFFFFFFFF, `b`=0x00000001, `cin`=0, `out_ready`=1 → next cycle `sum`=0x00000000, `cout`=1, `ovf`=0, `zero`=1 (flags build).
- `a`=0x7FFFFFFF, `b`=0x00000001, `cin`=0 → `sum`=0x80000000, `cout`=0, `ovf`=1, `zero`=0. `a`=0, `b`=0, `cin`=1 → `sum`=0x00000001.
- Back-to-back inputs 0x1+0x1, 0x2+0x2, 0x3+0x3 with `out_ready`=0:
  - First two accepted; `in_ready`=0 after the second.
  - Raising `out_ready` yields 0x2, 0x4, then 0x6 accepted and output in order.
  - Outputs stay stable while stalled.
- 1000 random operands with random `in_valid`/`out_ready` → results match `a+b+cin` in order with no loss; `in_ready` never depends combinationally on `out_ready`.
- FULL state, then `rst_n` low 1 cycle → `out_valid`=0 and `sum`=0; no stale result appears after release. Rebuild without `KSA_SUM_FLAGS_EN` → `ovf`=`zero`=0 for the 0x7FFFFFFF+1 case, `sum` unchanged.
